// File: rtl/axi4_wr_burst_pkg.sv
// Shared types and constants for the FIFO-to-AXI4 write burst master.
// State encoding, AXI burst/response codes and the AWSIZE helper.
package axi4_wr_burst_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AW,
    ST_DATA,
    ST_DROP
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // AWSIZE is log2 of the bytes per beat; lane count is a power of two.
  function automatic logic [2:0] f_awsize(input int strb_w);
    logic [2:0] s;
    s = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if ((1 << i) == strb_w) s = 3'(i);
    end
    return s;
  endfunction

endpackage

// File: rtl/axi4_wstrb_gen.sv
// Byte-strobe generator for the W channel.
// On the EOP beat the top i_mod byte lanes are cleared.
module axi4_wstrb_gen
  import axi4_wr_burst_pkg::*;
#(
  parameter int STRB_WIDTH = 64,
  parameter int MOD_WIDTH  = 6
) (
  input  logic                  i_eop,
  input  logic [MOD_WIDTH-1:0]  i_mod,
  output logic [STRB_WIDTH-1:0] o_wstrb
);

  always_comb begin
    o_wstrb = '1;
    if (i_eop) begin
      for (int j = 0; j < STRB_WIDTH; j++) begin
        if (j < int'(i_mod)) o_wstrb[STRB_WIDTH-1-j] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/axi4_wr_burst_mst.sv
// AXI4 INCR write master draining a packet FIFO, one burst per command.
// Tracks outstanding writes, drops error packets and flags length mismatches.
module axi4_wr_burst_mst
  import axi4_wr_burst_pkg::*;
#(
  parameter int DATA_WIDTH     = 512,
  parameter int STRB_WIDTH     = DATA_WIDTH / 8,
  parameter int MOD_WIDTH      = $clog2(STRB_WIDTH),
  parameter int FIFO_WIDTH     = 540,
  parameter int EOP_POS        = 519,
  parameter int ERR_POS        = 518,
  parameter int MOD_POS        = 512,
  parameter int ADDR_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int AXI_ID         = 0,
  parameter int MAX_OUTS       = 8,
  parameter int WR_ERR_DROP_EN = 1
) (
  input  logic                    clkr,
  input  logic                    reset_clkr,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [7:0]              cmd_len,
  output logic                    fifo_rd,
  input  logic [FIFO_WIDTH-1:0]   fifo_rdata,
  input  logic                    fifo_ef,
  input  logic                    fifo_sop,
  output logic                    awvalid,
  input  logic                    awready,
  output logic [ADDR_WIDTH-1:0]   awaddr,
  output logic [7:0]              awlen,
  output logic [2:0]              awsize,
  output logic [1:0]              awburst,
  output logic [ID_WIDTH-1:0]     awid,
  output logic [ID_WIDTH-1:0]     wid,
  output logic [DATA_WIDTH-1:0]   wdata,
  output logic [STRB_WIDTH-1:0]   wstrb,
  output logic                    wlast,
  output logic                    wvalid,
  input  logic                    wready,
  input  logic [ID_WIDTH-1:0]     bid,
  input  logic [1:0]              bresp,
  input  logic                    bvalid,
  output logic                    bready,
  input  logic [ID_WIDTH-1:0]     cfg_bid_id,
  output logic                    rsp_ok_cnt_en,
  output logic                    rsp_exok_cnt_en,
  output logic                    rsp_slverr_cnt_en,
  output logic                    rsp_decerr_cnt_en,
  output logic                    drop_cnt_en,
  output logic                    len_err_cnt_en,
  output logic [$clog2(MAX_OUTS):0] outs_cnt,
  output logic                    idle
);

  localparam int OW = $clog2(MAX_OUTS) + 1;

  state_t r_state;
  state_t w_nxt;

  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [7:0]            r_awlen;
  logic [7:0]            r_beat;
  logic [OW-1:0]         r_outs;
  logic                  r_lerr_seen;
  logic                  r_ok;
  logic                  r_exok;
  logic                  r_slverr;
  logic                  r_decerr;
  logic                  r_drop;
  logic                  r_lerr;

  logic                 w_eop;
  logic                 w_err;
  logic [MOD_WIDTH-1:0] w_mod;
  logic                 w_room;
  logic                 w_drop;
  logic                 w_start;
  logic                 w_acc;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_b_ev;
  logic                 w_bmatch;
  logic                 w_mis;
  logic                 w_unused;

  assign w_eop    = fifo_rdata[EOP_POS];
  assign w_err    = fifo_rdata[ERR_POS];
  assign w_mod    = fifo_rdata[MOD_POS +: MOD_WIDTH];
  assign w_unused = ^fifo_rdata;

  assign w_room  = r_outs < OW'(MAX_OUTS);
  assign w_drop  = (WR_ERR_DROP_EN != 0) && w_err;
  assign w_start = cmd_valid && !fifo_ef && fifo_sop && !reset_clkr;

  always_comb begin
    w_nxt     = r_state;
    cmd_ready = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    wlast     = 1'b0;
    fifo_rd   = 1'b0;
    w_acc     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start && w_drop) begin
          cmd_ready = 1'b1;
          w_nxt     = ST_DROP;
        end else if (w_start && w_room) begin
          cmd_ready = 1'b1;
          w_acc     = 1'b1;
          w_nxt     = ST_AW;
        end
      end
      ST_AW: begin
        awvalid = 1'b1;
        if (awready) w_nxt = ST_DATA;
      end
      ST_DATA: begin
        wvalid  = !fifo_ef;
        wlast   = (r_beat == r_awlen);
        fifo_rd = wvalid && wready;
        if (fifo_rd && wlast) w_nxt = ST_IDLE;
      end
      ST_DROP: begin
        fifo_rd = !fifo_ef;
        if (fifo_rd && w_eop) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

  assign w_aw_hs  = awvalid && awready;
  assign w_w_hs   = (r_state == ST_DATA) && fifo_rd;
  assign w_b_ev   = bvalid && (r_outs != '0);
  assign w_bmatch = w_b_ev && (bid == cfg_bid_id);
  // Report a length mismatch only on its first occurrence in a burst.
  assign w_mis    = w_w_hs && (w_eop != wlast) && !r_lerr_seen;

  always_ff @(posedge clkr or posedge reset_clkr) begin
    if (reset_clkr) begin
      r_state     <= ST_IDLE;
      r_awaddr    <= '0;
      r_awlen     <= '0;
      r_beat      <= '0;
      r_outs      <= '0;
      r_lerr_seen <= 1'b0;
      r_ok        <= 1'b0;
      r_exok      <= 1'b0;
      r_slverr    <= 1'b0;
      r_decerr    <= 1'b0;
      r_drop      <= 1'b0;
      r_lerr      <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_acc) begin
        r_awaddr    <= cmd_addr;
        r_awlen     <= cmd_len;
        r_beat      <= '0;
        r_lerr_seen <= 1'b0;
      end else begin
        if (w_w_hs) r_beat <= r_beat + 8'd1;
        if (w_mis) r_lerr_seen <= 1'b1;
      end
      unique case (1'b1)
        w_aw_hs && !w_b_ev: r_outs <= r_outs + OW'(1);
        !w_aw_hs && w_b_ev: r_outs <= r_outs - OW'(1);
        default:            r_outs <= r_outs;
      endcase
      r_ok     <= w_bmatch && (bresp == RESP_OKAY);
      r_exok   <= w_bmatch && (bresp == RESP_EXOKAY);
      r_slverr <= w_bmatch && (bresp == RESP_SLVERR);
      r_decerr <= w_bmatch && (bresp == RESP_DECERR);
      r_drop   <= (r_state == ST_DROP) && fifo_rd && w_eop;
      r_lerr   <= w_mis;
    end
  end

  axi4_wstrb_gen #(
    .STRB_WIDTH (STRB_WIDTH),
    .MOD_WIDTH  (MOD_WIDTH)
  ) u_wstrb (
    .i_eop   (w_eop),
    .i_mod   (w_mod),
    .o_wstrb (wstrb)
  );

  assign awaddr            = r_awaddr;
  assign awlen             = r_awlen;
  assign awsize            = f_awsize(STRB_WIDTH);
  assign awburst           = AXI_BURST_INCR;
  assign awid              = ID_WIDTH'(AXI_ID);
  assign wid               = ID_WIDTH'(AXI_ID);
  assign wdata             = fifo_rdata[DATA_WIDTH-1:0];
  assign bready            = 1'b1;
  assign rsp_ok_cnt_en     = r_ok;
  assign rsp_exok_cnt_en   = r_exok;
  assign rsp_slverr_cnt_en = r_slverr;
  assign rsp_decerr_cnt_en = r_decerr;
  assign drop_cnt_en       = r_drop;
  assign len_err_cnt_en    = r_lerr;
  assign outs_cnt          = r_outs;
  assign idle              = (r_state == ST_IDLE) && (r_outs == '0);

endmodule
